prv_trap_ctrl: RTL

- Privileged-side trap sequencer. It consumes the pipeline's exception, return and flush signals plus the raw interrupt lines, and produces the PC-redirect handshake (`priv_pc`, `insert_pc`, `intr`) back to the hazard unit.
- Owns `mepc`, `mcause`, `mtval` and `mstatus.MIE`/`MPIE`.
- Sits inside the priv block, between the hazard-unit side of `prv_pipeline_if` and the machine-mode CSR file.

---
 rtl/prv_trap_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/prv_trap_ctrl.sv
// prv_trap_ctrl: privileged-side trap sequencer.
//
// Takes exception, return and flush signals from the hazard unit plus the raw interrupt
// lines. Produces the PC-redirect handshake (priv_pc, insert_pc, intr). Owns mepc, mcause,
// mtval and mstatus.MIE/MPIE.
//
// Ports:
//   CLK, nRST                  clock, asynchronous active-low reset
//   fault_insn .. env_m        exception flags from hazard unit
//   ex_rmgmt, ex_rmgmt_cause   RISC-MGMT exception and cause index
//   ret                        MRET committing
//   pipe_clear                 pipeline drained, safe to redirect
//   epc, badaddr               faulting PC and fault address / instruction bits
//   timer_int, soft_int, ext_int   raw asynchronous interrupt lines
//   mie_en                     {MEIE, MSIE, MTIE}
//   mtvec                      trap vector CSR
//   mstatus_we/wmie/wmpie      CSR write port for MIE/MPIE
//   priv_pc, insert_pc, intr   redirect target, one-cycle strobe, flush request
//   mepc, mcause, mtval        CSR read values
//   mstatus_mie, mstatus_mpie  CSR read values
//   mip                        synchronized pending {MEIP, MSIP, MTIP}
module prv_trap_ctrl #(
    parameter int unsigned RMGMT_CAUSE_W    = 2,
    parameter int unsigned RMGMT_CAUSE_BASE = 24
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     fault_insn,
    input  logic                     mal_insn,
    input  logic                     illegal_insn,
    input  logic                     fault_l,
    input  logic                     mal_l,
    input  logic                     fault_s,
    input  logic                     mal_s,
    input  logic                     breakpoint,
    input  logic                     env_m,
    input  logic                     ex_rmgmt,
    input  logic [RMGMT_CAUSE_W-1:0] ex_rmgmt_cause,
    input  logic                     ret,
    input  logic                     pipe_clear,
    input  logic [31:0]              epc,
    input  logic [31:0]              badaddr,
    input  logic                     timer_int,
    input  logic                     soft_int,
    input  logic                     ext_int,
    input  logic [2:0]               mie_en,
    input  logic [31:0]              mtvec,
    input  logic                     mstatus_we,
    input  logic                     mstatus_wmie,
    input  logic                     mstatus_wmpie,
    output logic [31:0]              priv_pc,
    output logic                     insert_pc,
    output logic                     intr,
    output logic [31:0]              mepc,
    output logic [31:0]              mtval,
    output logic [31:0]              mcause,
    output logic                     mstatus_mie,
    output logic                     mstatus_mpie,
    output logic [2:0]               mip
);

    typedef enum logic [1:0] {StIdle, StTrapWait, StRetWait, StInsert} state_e;

    state_e      state_q, state_d;
    logic [2:0]  sync1_q, mip_q;
    logic [31:0] cause_q, epc_q, tval_q;
    logic [31:0] mepc_q, mcause_q, mtval_q, priv_pc_q;
    logic        mie_q, mpie_q;

    logic        exc_any, exc_tval, irq_take;
    logic [30:0] exc_code, irq_code;
    logic [2:0]  irq_pend;
    logic [31:0] trap_pc;

    // Fixed exception priority; tval carries badaddr only for address/insn faults.
    always_comb begin
        exc_any  = 1'b1;
        exc_tval = 1'b1;
        exc_code = 31'd0;
        if (fault_insn)        exc_code = 31'd1;
        else if (mal_insn)     exc_code = 31'd0;
        else if (illegal_insn) exc_code = 31'd2;
        else if (env_m)        begin exc_code = 31'd11; exc_tval = 1'b0; end
        else if (breakpoint)   exc_code = 31'd3;
        else if (mal_s)        exc_code = 31'd6;
        else if (mal_l)        exc_code = 31'd4;
        else if (fault_s)      exc_code = 31'd7;
        else if (fault_l)      exc_code = 31'd5;
        else if (ex_rmgmt) begin
            exc_code = 31'(RMGMT_CAUSE_BASE) + 31'(ex_rmgmt_cause);
            exc_tval = 1'b0;
        end else begin
            exc_any  = 1'b0;
            exc_tval = 1'b0;
        end
    end

    // {ext, soft, timer} in that priority order.
    always_comb begin
        irq_pend = mip_q & mie_en;
        irq_take = (|irq_pend) & mie_q;
        if (irq_pend[2])      irq_code = 31'd11;
        else if (irq_pend[1]) irq_code = 31'd3;
        else                  irq_code = 31'd7;
    end

    // Vectored mode only offsets interrupts; exceptions always land on the base.
    always_comb begin
        trap_pc = {mtvec[31:2], 2'b00};
        if (mtvec[1:0] == 2'b01 && cause_q[31]) begin
            trap_pc = trap_pc + {cause_q[29:0], 2'b00};
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (exc_any || irq_take) state_d = StTrapWait;
                else if (ret)            state_d = StRetWait;
            end
            StTrapWait, StRetWait: begin
                if (pipe_clear) state_d = StInsert;
            end
            StInsert: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync1_q   <= '0;
            mip_q     <= '0;
            cause_q   <= '0;
            epc_q     <= '0;
            tval_q    <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
            mtval_q   <= '0;
            priv_pc_q <= '0;
            mie_q     <= 1'b0;
            mpie_q    <= 1'b0;
        end else begin
            sync1_q <= {ext_int, soft_int, timer_int};
            mip_q   <= sync1_q;
            if (state_q == StIdle) begin
                if (exc_any) begin
                    cause_q <= {1'b0, exc_code};
                    epc_q   <= epc & ~32'd3;
                    tval_q  <= exc_tval ? badaddr : 32'd0;
                end else if (irq_take) begin
                    cause_q <= {1'b1, irq_code};
                    epc_q   <= epc & ~32'd3;
                    tval_q  <= 32'd0;
                end
                if (mstatus_we) begin
                    mie_q  <= mstatus_wmie;
                    mpie_q <= mstatus_wmpie;
                end
            end
            if (state_q == StTrapWait && pipe_clear) begin
                mepc_q    <= epc_q;
                mcause_q  <= cause_q;
                mtval_q   <= tval_q;
                mpie_q    <= mie_q;
                mie_q     <= 1'b0;
                priv_pc_q <= trap_pc;
            end
            if (state_q == StRetWait && pipe_clear) begin
                mie_q     <= mpie_q;
                mpie_q    <= 1'b1;
                priv_pc_q <= mepc_q;
            end
        end
    end

    assign priv_pc      = priv_pc_q;
    assign insert_pc    = (state_q == StInsert);
    assign intr         = (state_q == StTrapWait) || (state_q == StRetWait);
    assign mepc         = mepc_q;
    assign mcause       = mcause_q;
    assign mtval        = mtval_q;
    assign mstatus_mie  = mie_q;
    assign mstatus_mpie = mpie_q;
    assign mip          = mip_q;

endmodule
